// File: rtl/ntt_bitrev_reorder.sv
// ============================================================================
// Module   : ntt_bitrev_reorder
// Purpose  : Ping-pong reorder buffer turning a bit-reversed NTT result stream
//            into natural order; optional NTT_REORDER_MODRED_EN adds a final
//            conditional subtraction of MODULUS before storage.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ntt_bitrev_reorder #(
    parameter int W       = 32,
    parameter int N       = 16,
    parameter int MODULUS = 7681
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         out_last
);

    localparam int              c_LG   = $clog2(N);
    localparam logic [c_LG-1:0] c_LAST = c_LG'(N - 1);
    localparam logic [W-1:0]    c_MOD  = W'(MODULUS);

    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [c_LG-1:0] wr_cnt_q, wr_cnt_d;
    logic [c_LG-1:0] rd_cnt_q, rd_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [W-1:0]    bank_q [0:1][0:N-1];

    logic            w_accept;
    logic            w_load;
    logic [c_LG-1:0] w_wr_addr;
    logic [W-1:0]    w_wr_data;

    assign in_ready  = !full_q[wr_bank_q];
    assign w_accept  = in_valid && in_ready;
    assign w_load    = full_q[rd_bank_q] && (!out_valid_q || out_ready);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        w_wr_addr = '0;
        for (int k = 0; k < c_LG; k++) begin
            w_wr_addr[k] = wr_cnt_q[c_LG-1-k];
        end
    end

`ifdef NTT_REORDER_MODRED_EN
    // Montgomery output lies in [0, 2*MODULUS); one subtraction normalises it.
    assign w_wr_data = (in_data >= c_MOD) ? (in_data - c_MOD) : in_data;
`else
    logic [W-1:0] w_unused_mod;
    assign w_unused_mod = c_MOD;
    assign w_wr_data    = in_data;
`endif

    // Sample storage carries no reset; validity is tracked by full_q alone.
    always_ff @(posedge clk) begin
        if (w_accept && start) begin
            bank_q[wr_bank_q][w_wr_addr] <= w_wr_data;
        end
    end

    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (w_accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == c_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Read frees the bank it drains; write only ever fills the other one.
        if (w_load) begin
            out_data_d  = bank_q[rd_bank_q][rd_cnt_q];
            out_last_d  = (rd_cnt_q == c_LAST);
            out_valid_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + 1'b1;
            if (rd_cnt_q == c_LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (!start) begin
            full_d      = '0;
            wr_bank_d   = 1'b0;
            rd_bank_d   = 1'b0;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ntt_bitrev_reorder.sv
// ============================================================================
// Module   : tb_ntt_bitrev_reorder
// Purpose  : Self-checking bench for ntt_bitrev_reorder (table vectors plus a
//            scoreboard queue of expected natural-order words).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ntt_bitrev_reorder;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int LG = 4;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout_raw;
        logic [W-1:0] dout_mod;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         out_last;

    ntt_bitrev_reorder #(.W(W), .N(N), .MODULUS(7681)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    vec_t         tbl [32];
    exp_t         q [$];
    logic [W-1:0] mfr [N];
    int           mcnt;
    int           tbl_base;
    int           checks;
    int           failures;
    int           cyc = 0;
    int           out_cnt;
    int           first_out_cyc;
    int           last_out_cyc;
    int           last_in_cyc;
    int           first_in_cyc;

    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;
    exp_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LG-1:0] brev(input logic [LG-1:0] i);
        logic [LG-1:0] r;
        for (int k = 0; k < LG; k++) r[k] = i[LG-1-k];
        return r;
    endfunction

    function automatic logic [W-1:0] stored(input logic [W-1:0] d);
`ifdef NTT_REORDER_MODRED_EN
        return (d >= 32'd7681) ? d - 32'd7681 : d;
`else
        return d;
`endif
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_accept(input logic [W-1:0] d);
        exp_t e;
        if (first_in_cyc < 0) first_in_cyc = cyc;
        mfr[brev(mcnt[LG-1:0])] = stored(d);
        mcnt++;
        if (mcnt == N) begin
            for (int j = 0; j < N; j++) begin
                if (tbl_base >= 0) begin
`ifdef NTT_REORDER_MODRED_EN
                    e.data = tbl[tbl_base+j].dout_mod;
`else
                    e.data = tbl[tbl_base+j].dout_raw;
`endif
                end else begin
                    e.data = mfr[j];
                end
                e.last = (j == N-1);
                q.push_back(e);
            end
            mcnt        = 0;
            last_in_cyc = cyc;
        end
    endtask

    task automatic send(input logic [W-1:0] d, output bit acc);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        acc = in_ready;
        if (acc) model_accept(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_retry(input logic [W-1:0] d);
        bit acc;
        for (int t = 0; t < 100; t++) begin
            send(d, acc);
            if (acc) return;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout actual=not_accepted required=accepted");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) done = 1'b1;
        end
        check("drain_pending", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every transfer pops one expected word; stalls must hold.
    always @(negedge clk) begin
        if (rst || !start) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold actual=%0d/%0b/%0b required=%0d/%0b/1",
                             out_data, out_last, out_valid, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=%0d required=none", out_data);
                end else begin
                    mon_e = q.pop_front();
                    if (out_data !== mon_e.data || out_last !== mon_e.last) begin
                        failures++;
                        $display("FAIL out_word actual=%0d/last%0b required=%0d/last%0b",
                                 out_data, out_last, mon_e.data, mon_e.last);
                    end
                end
                out_cnt++;
                if (out_cnt == 1) first_out_cyc = cyc;
                last_out_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        logic [W-1:0] sf_out [16] = '{100, 108, 104, 112, 102, 110, 106, 114,
                                      101, 109, 105, 113, 103, 111, 107, 115};
        logic [W-1:0] md_in  [16] = '{7700, 7680, 15361, 7681, 4, 5, 6, 7,
                                      8, 9, 10, 11, 12, 13, 14, 15};
        logic [W-1:0] md_raw [16] = '{7700, 8, 4, 12, 15361, 10, 6, 14,
                                      7680, 9, 5, 13, 7681, 11, 7, 15};
        logic [W-1:0] md_mod [16] = '{19, 8, 4, 12, 7680, 10, 6, 14,
                                      7680, 9, 5, 13, 0, 11, 7, 15};
        bit acc;

        for (int i = 0; i < 16; i++) begin
            tbl[i].din         = 100 + i;
            tbl[i].dout_raw    = sf_out[i];
            tbl[i].dout_mod    = sf_out[i];
            tbl[16+i].din      = md_in[i];
            tbl[16+i].dout_raw = md_raw[i];
            tbl[16+i].dout_mod = md_mod[i];
        end

        checks = 0; failures = 0; mcnt = 0; tbl_base = -1;
        out_cnt = 0; first_out_cyc = 0; last_out_cyc = 0;
        last_in_cyc = 0; first_in_cyc = -1; prev_stall = 1'b0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // Reset / idle
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        @(posedge clk); #1;

        // Single frame from the vector table, with latency
        tbl_base = 0; out_cnt = 0;
        for (int i = 0; i < 16; i++) send_retry(tbl[i].din);
        drain();
        check("frame_latency", first_out_cyc - last_in_cyc, 2);
        check("frame_count", out_cnt, 16);

        // Four back-to-back frames
        tbl_base = -1; out_cnt = 0; first_in_cyc = -1;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < N; i++) begin
                send(1000*(f+1) + i, acc);
                check("b2b_in_ready", acc, 1);
            end
        drain();
        check("b2b_count", out_cnt, 64);
        check("b2b_no_gap", last_out_cyc - first_out_cyc, 63);
        check("b2b_lag", first_out_cyc - first_in_cyc, N + 1);

        // Backpressure: both banks fill, extra words refused
        out_ready = 1'b0; out_cnt = 0;
        for (int i = 0; i < 32; i++) send_retry(2000 + i);
        for (int i = 0; i < 5; i++) begin
            send(9999, acc);
            check("full_in_ready", acc, 0);
        end
        idle(3);
        @(negedge clk);
        check("stall_first_valid", out_valid, 1);
        check("stall_first_word", out_data, 2000);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        check("bp_count", out_cnt, 32);

        // Abort via start low after 7 inputs
        out_cnt = 0;
        for (int i = 0; i < 7; i++) send_retry(3000 + i);
        start = 1'b0;
        idle(2);
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        mcnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 16; i++) send_retry(4000 + i);
        drain();
        check("abort_count", out_cnt, 16);

        // Abort via asynchronous rst pulse after 7 inputs
        out_cnt = 0;
        for (int i = 0; i < 7; i++) send_retry(5000 + i);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        mcnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) send_retry(6000 + i);
        drain();
        check("arst_count", out_cnt, 16);

        // Modular-reduction vectors (expected value selected by build option)
        tbl_base = 16; out_cnt = 0;
        for (int i = 0; i < 16; i++) send_retry(tbl[16+i].din);
        drain();
        check("modred_count", out_cnt, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ntt_bitrev_reorder.md
# ntt_bitrev_reorder

Output reorder buffer placed directly downstream of the last SDF NTT stage. It consumes the serial, bit-reversed-order result stream produced by the final stage's Montgomery multiplier and emits each N-point frame in natural order. A ping-pong pair of N-word banks lets one frame be written while the previous one is read out, so a continuous one-word-per-cycle stream is sustained. The output side uses a valid/ready handshake toward the consumer.

## Interface
- W, 32, data word width
- N, 16, frame length in points; power of two, ≥ 2
- MODULUS, 7681, NTT modulus; used only when NTT_REORDER_MODRED_EN is defined
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  run enable; low = synchronous clear of all state, same effect as rst
- in_valid  input  1  in_data carries a result word this cycle
- in_data  input  W  result word from the last NTT stage, bit-reversed order
- in_ready  output  1  a word is accepted this cycle when in_valid && in_ready
- out_valid  output  1  out_data holds a natural-order word
- out_data  output  W  reordered word
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready
- out_last  output  1  qualifies out_data as index N-1 of its frame

## Operation
- Storage: bank[0..1][0..N-1] of W bits; per-bank flag full[b]; pointers wr_bank, rd_bank (1 bit each); counters wr_cnt, rd_cnt of log2(N) bits.
- Write side: in_ready = !full[wr_bank]. On accept, store in_data at bank[wr_bank][bitrev(wr_cnt)], wr_cnt += 1. On the accept with wr_cnt == N-1: wr_cnt wraps to 0, full[wr_bank] set, wr_bank toggles.
- bitrev(i): log2(N)-bit reversal of i (N=16: 1→8, 2→4, 3→12).
- Read side: registered output stage. Load condition: full[rd_bank] && (!out_valid || out_ready). On load, out_data ← bank[rd_bank][rd_cnt], out_last ← (rd_cnt == N-1), out_valid ← 1, rd_cnt += 1. On the load with rd_cnt == N-1: rd_cnt wraps, full[rd_bank] cleared, rd_bank toggles.
- If out_valid && out_ready and no load occurs, out_valid ← 0.
- Stall: while out_valid && !out_ready, out_data and out_last hold unchanged; no load.
- Simultaneous events: set of full[] by the write side and clear of full[] by the read side in the same cycle always address different banks (write never targets a full bank); both take effect.
- Both banks full: in_ready low; in_valid ignored; no data lost or overwritten.
- A bank freed on a given edge is writable in the following cycle (output register already holds its last word).
- rst or !start mid-frame: partial frames discarded, all flags, pointers and counters cleared; no residual output.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_last 0; full[] 0, wr_bank 0, rd_bank 0, wr_cnt 0, rd_cnt 0.
- Latency: last word of a frame accepted in cycle t → out_valid high with word 0 in cycle t+2 (out_ready high).
- Throughput: with in_valid and out_ready held high, in_ready never drops and one word per cycle flows in and out indefinitely; output lags input by N+1 cycles.
- in_ready is combinational from registered state only; no combinational path from in_valid or out_ready to any output except through registers.

## Configuration
- NTT_REORDER_MODRED_EN defined: final conditional subtraction applied before writing to the bank: stored = (in_data ≥ MODULUS) ? in_data − MODULUS : in_data. This brings Montgomery results from [0, 2·MODULUS) into [0, MODULUS). Comparison and subtraction are unsigned, W bits.
- Not defined: in_data is stored unmodified; MODULUS is unused.

## Test plan
- Reset/idle: assert rst with in_valid low → out_valid 0, out_data 0, in_ready 1; after release, no output appears.
- Single frame: inputs 100+i for i=0..15, out_ready=1 → outputs 100,108,104,112,102,110,… (word j = 100+bitrev(j)); out_last only on the 16th; first out_valid two cycles after the 16th input.
- Back-to-back: 4 continuous frames, out_ready=1 → in_ready constantly 1, 64 outputs in correct per-frame order, no gaps after the first.
- Backpressure: out_ready=0 during streaming → out_data holds; after 2 full frames in_ready=0 and extra inputs are ignored; release out_ready → both frames emitted intact in order.
- Mid-frame abort: drop start after 7 inputs, then send a full frame → only the new frame appears; same check with asynchronous rst pulse.
- Macro on: in_data 7700 → stored 19; 7680 → 7680; 15361 → 7680. Macro off: 7700 → 7700.
